// File: rtl/softmax_seq.sv
// Softmax sequencer: buffers N Q8.8 scores and tracks their max, then runs exp(x - max)
// through an exp LUT while accumulating the sum, and finally streams exponentials with the sum.
module softmax_seq #(
  parameter int unsigned N     = 8,
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned SUM_W = OUT_W + $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic [SUM_W-1:0] sum_out,
  output logic             busy
);

  localparam int unsigned IdxW = $clog2(N);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  typedef enum logic [1:0] {StLoad, StExp, StOut} state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic signed [IN_W-1:0]  max_q, max_d;
  logic [SUM_W-1:0]        acc_q, acc_d;
  logic [SUM_W-1:0]        sum_q, sum_d;
  logic [IN_W-1:0]         score_q [N];
  logic [OUT_W-1:0]        exp_q [N];
  logic                    score_we, exp_we;
  logic signed [IN_W:0]    diff_wide;
  logic signed [IN_W-1:0]  diff;
  logic [OUT_W-1:0]        lut_val;

  // exp_lut: floor to integer, clamp to [-8,0], Q0.16 result.
  function automatic logic [OUT_W-1:0] exp_lut(input logic signed [IN_W-1:0] x);
    logic signed [IN_W-9:0] ip;
    logic [3:0]             k;
    ip = x[IN_W-1:8];
    if (ip > 0) begin
      k = 4'd0;
    end else if (ip < -8) begin
      k = 4'd8;
    end else begin
      k = 4'(-ip);
    end
    case (k)
      4'd0:    exp_lut = OUT_W'(32'd65535);
      4'd1:    exp_lut = OUT_W'(32'd24109);
      4'd2:    exp_lut = OUT_W'(32'd8869);
      4'd3:    exp_lut = OUT_W'(32'd3265);
      4'd4:    exp_lut = OUT_W'(32'd1202);
      4'd5:    exp_lut = OUT_W'(32'd442);
      4'd6:    exp_lut = OUT_W'(32'd163);
      4'd7:    exp_lut = OUT_W'(32'd60);
      default: exp_lut = OUT_W'(32'd22);
    endcase
  endfunction

  // The difference is never positive, so overflow of the wide result only happens downward.
  always_comb begin
    diff_wide = {score_q[idx_q][IN_W-1], score_q[idx_q]} - {max_q[IN_W-1], max_q};
    if (diff_wide[IN_W] != diff_wide[IN_W-1]) begin
      diff = {1'b1, {(IN_W-1){1'b0}}};
    end else begin
      diff = diff_wide[IN_W-1:0];
    end
    lut_val = exp_lut(diff);
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    max_d    = max_q;
    acc_d    = acc_q;
    sum_d    = sum_q;
    score_we = 1'b0;
    exp_we   = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (in_valid) begin
          score_we = 1'b1;
          if (idx_q == '0 || $signed(in_data) > max_q) begin
            max_d = in_data;
          end
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            acc_d   = '0;
            state_d = StExp;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StExp: begin
        exp_we = 1'b1;
        acc_d  = acc_q + SUM_W'(lut_val);
        if (idx_q == LastIdx) begin
          sum_d   = acc_q + SUM_W'(lut_val);
          idx_d   = '0;
          state_d = StOut;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StOut: begin
        if (out_ready) begin
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = StLoad;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StLoad;
      idx_q   <= '0;
      max_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      max_q   <= max_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
    end
  end

  always_ff @(posedge clk) begin
    if (score_we) score_q[idx_q] <= in_data;
    if (exp_we)   exp_q[idx_q]   <= lut_val;
  end

  always_comb begin
    in_ready  = (state_q == StLoad);
    out_valid = (state_q == StOut);
    busy      = (state_q != StLoad);
    out_last  = (state_q == StOut) && (idx_q == LastIdx);
    out_data  = (state_q == StOut) ? exp_q[idx_q] : '0;
    sum_out   = sum_q;
  end

endmodule

// File: tb/tb_softmax_seq.sv
// Bench for softmax_seq: directed test-plan vectors plus random vectors, all scored against
// a behavioural softmax-numerator model.
module tb_softmax_seq;
  localparam int N     = 8;
  localparam int IN_W  = 16;
  localparam int OUT_W = 16;
  localparam int SUM_W = 19;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [OUT_W-1:0] out_data;
  logic             out_last;
  logic [SUM_W-1:0] sum_out;
  logic             busy;

  softmax_seq #(.N(N), .IN_W(IN_W), .OUT_W(OUT_W), .SUM_W(SUM_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .sum_out(sum_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int tbl[9] = '{65535, 24109, 8869, 3265, 1202, 442, 163, 60, 22};

  // model state
  int cur[$];
  int exp_q[$];
  int exp_sum = 0;
  int last_sum = 0;
  int cyc = 0;
  int rise_at = 1 << 30;
  int last_in_cyc = 0;
  int rise_cyc = 0;
  // captures from the DUT for directed literal checks
  int dut_outs[$];
  int dut_sum = 0;
  int rdy_mode = 0;
  // stall stability
  logic             prev_ov = 1'b0, prev_or = 1'b0, prev_last = 1'b0;
  logic [OUT_W-1:0] prev_data = '0;
  logic [SUM_W-1:0] prev_sum = '0;

  task automatic chk(input string nm, input longint act, input longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic int model_exp(input int s, input int m);
    int d, ip;
    d = s - m;
    if (d < -32768) d = -32768;
    ip = $rtoi($floor(real'(d) / 256.0));
    if (ip < -8) ip = -8;
    if (ip > 0) ip = 0;
    return tbl[-ip];
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_sum_out", sum_out, 0);
      chk("rst_busy", busy, 0);
      cur.delete();
      exp_q.delete();
      last_sum = 0;
      rise_at = 1 << 30;
      prev_ov = 1'b0;
    end else begin
      chk("out_valid", out_valid, (exp_q.size() != 0 && cyc >= rise_at) ? 1 : 0);
      chk("in_ready", in_ready, (exp_q.size() == 0) ? 1 : 0);
      chk("busy", busy, (exp_q.size() != 0) ? 1 : 0);
      if (out_valid && !prev_ov) rise_cyc = cyc;
      if (out_valid && exp_q.size() != 0) begin
        chk("out_data", out_data, exp_q[0]);
        chk("out_last", out_last, (exp_q.size() == 1) ? 1 : 0);
        chk("sum_out", sum_out, exp_sum);
      end else if (!out_valid) begin
        chk("sum_hold", sum_out, last_sum);
      end
      if (prev_ov && !prev_or) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
        chk("stall_last", out_last, prev_last);
        chk("stall_sum", sum_out, prev_sum);
      end
      if (in_valid && in_ready) begin
        cur.push_back(int'($signed(in_data)));
        if (cur.size() == N) begin
          int mx, s, e;
          mx = cur[0];
          foreach (cur[i]) if (cur[i] > mx) mx = cur[i];
          s = 0;
          foreach (cur[i]) begin
            e = model_exp(cur[i], mx);
            exp_q.push_back(e);
            s += e;
          end
          exp_sum = s;
          rise_at = cyc + N + 1;
          last_in_cyc = cyc;
          cur.delete();
        end
      end
      if (out_valid && out_ready) begin
        dut_outs.push_back(int'(out_data));
        dut_sum = int'(sum_out);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (exp_q.size() == 0) last_sum = exp_sum;
      end
      prev_ov   = out_valid;
      prev_or   = out_ready;
      prev_data = out_data;
      prev_last = out_last;
      prev_sum  = sum_out;
    end
  end

  always @(posedge clk) begin
    #1;
    out_ready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send_vec(input logic [IN_W-1:0] v[N], input int gap);
    bit acc;
    int w;
    for (int i = 0; i < N; i++) begin
      if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = v[i];
      w = 0;
      do begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        w++;
      end while (!acc && w < 200);
      if (!acc) chk("in_accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while ((exp_q.size() != 0 || cur.size() != 0) && w < 500) begin
      @(posedge clk);
      w++;
    end
    if (w >= 500) chk("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  logic [IN_W-1:0] v[N];
  int ramp_exp[N] = '{65535, 24109, 8869, 3265, 1202, 442, 163, 60};

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("model_half", model_exp(-128, 0), 24109);
    chk("model_sat", model_exp(-32768, 32767), 22);
    chk("model_zero", model_exp(256, 256), 65535);
    chk("model_floor", model_exp(-300, 0), 8869);

    // uniform
    foreach (v[i]) v[i] = 16'h0100;
    dut_outs.delete();
    send_vec(v, 0);
    wait_drain();
    chk("uniform_sum", dut_sum, 524280);
    chk("uniform_hs", dut_outs.size(), 8);
    chk("uniform_latency", rise_cyc - last_in_cyc, 9);
    foreach (dut_outs[i]) chk("uniform_val", dut_outs[i], 65535);

    // ramp
    foreach (v[i]) v[i] = 16'(-(i * 256));
    dut_outs.delete();
    send_vec(v, 0);
    wait_drain();
    chk("ramp_sum", dut_sum, 103645);
    chk("ramp_hs", dut_outs.size(), 8);
    foreach (dut_outs[i]) if (i < N) chk("ramp_val", dut_outs[i], ramp_exp[i]);

    // saturation
    v[0] = 16'h7FFF;
    for (int i = 1; i < N; i++) v[i] = 16'h8000;
    dut_outs.delete();
    send_vec(v, 0);
    wait_drain();
    chk("sat_sum", dut_sum, 65689);
    foreach (dut_outs[i]) chk("sat_val", dut_outs[i], (i == 0) ? 65535 : 22);

    // backpressure
    foreach (v[i]) v[i] = 16'h0100;
    dut_outs.delete();
    rdy_mode = 1;
    send_vec(v, 0);
    wait_drain();
    rdy_mode = 0;
    chk("bp_hs", dut_outs.size(), 8);
    chk("bp_sum", dut_sum, 524280);

    // reset mid-EXP: sum_out still holds the previous vector's sum until rst
    send_vec(v, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_sum", sum_out, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    foreach (v[i]) v[i] = 16'(-(i * 256));
    dut_outs.delete();
    send_vec(v, 0);
    wait_drain();
    chk("post_rst_sum", dut_sum, 103645);
    chk("post_rst_hs", dut_outs.size(), 8);
    foreach (dut_outs[i]) if (i < N) chk("post_rst_val", dut_outs[i], ramp_exp[i]);

    // input gaps
    dut_outs.delete();
    send_vec(v, 1);
    wait_drain();
    chk("gap_sum", dut_sum, 103645);
    chk("gap_hs", dut_outs.size(), 8);
    foreach (dut_outs[i]) if (i < N) chk("gap_val", dut_outs[i], ramp_exp[i]);

    // random vectors sent back to back; in_valid stays high while the DUT is busy
    for (int n = 0; n < 20; n++) begin
      int base = $urandom_range(0, 65535);
      foreach (v[i]) begin
        if (n % 3 == 0) v[i] = 16'($urandom);
        else v[i] = 16'(base + $urandom_range(0, 2560) - 1280);
      end
      rdy_mode = $urandom_range(0, 1);
      send_vec(v, $urandom_range(0, 2));
      in_valid = 1'b1;
      in_data  = 16'($urandom);
    end
    in_valid = 1'b0;
    wait_drain();
    rdy_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
